// File: rtl/fifo_wr_ptr_ctrl.sv
// Write-side pointer controller for an async FIFO: accepts writes, owns the Gray write pointer, raises full.
// Latency: mem_wr_en/mem_waddr are combinational from wr_req; wfull/wr_drop/wr_ptr_gray register 1 cycle later.
// Backpressure: writes are refused while wfull and flagged on wr_drop. Macro WR_ALMOST_FULL_EN adds walmost_full/wlevel.
module fifo_wr_ptr_ctrl #(
    parameter int ADDR_SIZE   = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AF_MARGIN   = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 wr_req,
    input  logic [ADDR_SIZE:0]   rd_ptr_gray,
    output logic [ADDR_SIZE:0]   wr_ptr_gray,
    output logic                 mem_wr_en,
    output logic [ADDR_SIZE-1:0] mem_waddr,
    output logic                 wfull,
    output logic                 wr_drop,
    output logic                 walmost_full,
    output logic [ADDR_SIZE:0]   wlevel
);
    localparam int AS = ADDR_SIZE;
    // Inverting the top two Gray bits is the Gray image of "read pointer + depth".
    localparam logic [AS:0] FULL_FLIP = (AS+1)'(3) << (AS-1);

    generate
        if (ADDR_SIZE < 1 || SYNC_STAGES < 2 || AF_MARGIN < 1 || AF_MARGIN > (2**ADDR_SIZE) - 1) begin : g_bad_param
            $error("fifo_wr_ptr_ctrl: illegal parameter combination");
        end
    endgenerate

    logic [AS:0] wbin;
    logic [AS:0] wbin_next;
    logic [AS:0] wgray_next;
    logic [AS:0] rq [SYNC_STAGES];
    logic [AS:0] rq_s;
    logic        accept;

    assign accept     = wr_req & ~wfull;
    assign mem_wr_en  = accept;
    assign mem_waddr  = wbin[AS-1:0];
    assign wbin_next  = wbin + (AS+1)'(accept);
    assign wgray_next = wbin_next ^ (wbin_next >> 1);
    assign rq_s       = rq[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                rq[i] <= '0;
            end
        end else begin
            rq[0] <= rd_ptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                rq[i] <= rq[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wbin        <= '0;
            wr_ptr_gray <= '0;
            wfull       <= 1'b0;
            wr_drop     <= 1'b0;
        end else begin
            wbin        <= wbin_next;
            wr_ptr_gray <= wgray_next;
            wfull       <= (wgray_next == (rq_s ^ FULL_FLIP));
            wr_drop     <= wr_req & wfull;
        end
    end

`ifdef WR_ALMOST_FULL_EN
    localparam logic [AS:0] AF_LIMIT = (AS+1)'((2**AS) - AF_MARGIN);

    logic [AS:0] rbin_s;
    logic [AS:0] lvl;

    always_comb begin
        rbin_s = '0;
        for (int i = 0; i <= AS; i++) begin
            rbin_s[i] = ^(rq_s >> i);
        end
    end

    assign lvl = wbin_next - rbin_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wlevel       <= '0;
            walmost_full <= 1'b0;
        end else begin
            wlevel       <= lvl;
            walmost_full <= (lvl >= AF_LIMIT);
        end
    end
`else
    assign wlevel       = '0;
    assign walmost_full = 1'b0;
`endif

endmodule
